// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: controller state codes, pointer/count widths.
// Imported by the FIFO FSM, the address calculator and the FIFO top.
package fifo_pkg;

  localparam int FIFO_AW = 3;
  localparam int FIFO_CW = FIFO_AW + 1;

  typedef logic [2:0] state_t;

  localparam state_t INIT     = 3'b000;
  localparam state_t READ     = 3'b001;
  localparam state_t WRITE    = 3'b010;
  localparam state_t RD_ERROR = 3'b011;
  localparam state_t WR_ERROR = 3'b100;
  localparam state_t NO_OP    = 3'b101;

  // Codes 110/111 are unused; the calculator treats them as NO_OP.
  function automatic logic is_legal(input state_t s);
    return (s <= NO_OP);
  endfunction

endpackage

// File: rtl/fifo_cal_addr_comb.sv
// Combinational decode of FIFO state into enables and next pointers.
// In: state, head, tail, data_count. Out: we_d, re_d, *_d next values.
// Optional macro FIFO_CAL_ADDR_GUARD_EN blocks WRITE when full and
// READ when empty (treated as WR_ERROR / RD_ERROR: hold, no enable).
module fifo_cal_addr_comb
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int CW = FIFO_CW
) (
  input  logic [2:0]    state,
  input  logic [AW-1:0] head,
  input  logic [AW-1:0] tail,
  input  logic [CW-1:0] data_count,
  output logic          we_d,
  output logic          re_d,
  output logic [AW-1:0] head_d,
  output logic [AW-1:0] tail_d,
  output logic [CW-1:0] count_d
);

  logic is_init;
  logic is_write;
  logic is_read;
  logic do_write;
  logic do_read;

  assign is_init  = (state == INIT);
  assign is_write = (state == WRITE);
  assign is_read  = (state == READ);

`ifdef FIFO_CAL_ADDR_GUARD_EN
  logic full;
  logic empty;

  assign full     = (data_count == CW'(2 ** AW));
  assign empty    = (data_count == '0);
  assign do_write = is_write & ~full;
  assign do_read  = is_read & ~empty;
`else
  assign do_write = is_write;
  assign do_read  = is_read;
`endif

  // Hold is the default: covers NO_OP, both error states,
  // illegal codes and (with the guard) blocked accesses.
  always_comb begin
    we_d    = 1'b0;
    re_d    = 1'b0;
    head_d  = head;
    tail_d  = tail;
    count_d = data_count;
    unique case (1'b1)
      is_init: begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      do_write: begin
        we_d    = 1'b1;
        tail_d  = tail + 1'b1;
        count_d = data_count + 1'b1;
      end
      do_read: begin
        re_d    = 1'b1;
        head_d  = head + 1'b1;
        count_d = data_count - 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/fifo_cal_addr.sv
// Registered FIFO address/count calculator, one cycle input-to-output.
// Ports: clk, rst (sync, active high), state/head/tail/data_count in;
// we, re, next_head, next_tail, next_data_count out (all registered).
// Optional macro: FIFO_CAL_ADDR_GUARD_EN (full/empty access guard).
module fifo_cal_addr
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int CW = FIFO_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    state,
  input  logic [AW-1:0] head,
  input  logic [AW-1:0] tail,
  input  logic [CW-1:0] data_count,
  output logic          we,
  output logic          re,
  output logic [AW-1:0] next_head,
  output logic [AW-1:0] next_tail,
  output logic [CW-1:0] next_data_count
);

  logic          we_d;
  logic          re_d;
  logic [AW-1:0] head_d;
  logic [AW-1:0] tail_d;
  logic [CW-1:0] count_d;

  fifo_cal_addr_comb #(
    .AW(AW),
    .CW(CW)
  ) u_comb (
    .state      (state),
    .head       (head),
    .tail       (tail),
    .data_count (data_count),
    .we_d       (we_d),
    .re_d       (re_d),
    .head_d     (head_d),
    .tail_d     (tail_d),
    .count_d    (count_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      we              <= 1'b0;
      re              <= 1'b0;
      next_head       <= '0;
      next_tail       <= '0;
      next_data_count <= '0;
    end else begin
      we              <= we_d;
      re              <= re_d;
      next_head       <= head_d;
      next_tail       <= tail_d;
      next_data_count <= count_d;
    end
  end

endmodule

// File: tb/tb_fifo_cal_addr.sv
// Directed table-driven bench for fifo_cal_addr.
// Inputs change on negedge; outputs checked 1 time unit after posedge.
module tb_fifo_cal_addr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state = 3'b000;
  logic [2:0] head = '0;
  logic [2:0] tail = '0;
  logic [3:0] data_count = '0;
  logic       we;
  logic       re;
  logic [2:0] next_head;
  logic [2:0] next_tail;
  logic [3:0] next_data_count;

  int n_run = 0;
  int n_fail = 0;

  fifo_cal_addr dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .head            (head),
    .tail            (tail),
    .data_count      (data_count),
    .we              (we),
    .re              (re),
    .next_head       (next_head),
    .next_tail       (next_tail),
    .next_data_count (next_data_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic [2:0] st;
    logic [2:0] h;
    logic [2:0] t;
    logic [3:0] c;
    logic       ewe;
    logic       ere;
    logic [2:0] eh;
    logic [2:0] et;
    logic [3:0] ec;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  function automatic vec_t mk(
    input logic r, input logic [2:0] st,
    input logic [2:0] h, input logic [2:0] t, input logic [3:0] c,
    input logic ewe, input logic ere,
    input logic [2:0] eh, input logic [2:0] et, input logic [3:0] ec);
    vec_t v;
    v = '{r, st, h, t, c, ewe, ere, eh, et, ec};
    return v;
  endfunction

  task automatic check(input string name, input logic [13:0] act,
                       input logic [13:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got we/re/h/t/c=%b/%b/%0d/%0d/%0d want %b/%b/%0d/%0d/%0d",
               name, act[13], act[12], act[11:9], act[8:6], act[5:0],
               exp[13], exp[12], exp[11:9], exp[8:6], exp[5:0]);
    end
  endtask

  function automatic logic [13:0] outs();
    return {we, re, next_head, next_tail, 2'b00, next_data_count};
  endfunction

  function automatic logic [13:0] pack(
    input logic w, input logic r, input logic [2:0] h,
    input logic [2:0] t, input logic [3:0] c);
    return {w, r, h, t, 2'b00, c};
  endfunction

  task automatic drive(input logic r, input logic [2:0] st,
                       input logic [2:0] h, input logic [2:0] t,
                       input logic [3:0] c);
    @(negedge clk);
    rst = r;
    state = st;
    head = h;
    tail = t;
    data_count = c;
  endtask

  initial begin
    vec[0]  = mk(1, 3'b010, 1, 2, 5, 0, 0, 0, 0, 0);
    vec[1]  = mk(0, 3'b010, 1, 2, 5, 1, 0, 1, 3, 6);
    vec[2]  = mk(0, 3'b000, 1, 2, 5, 0, 0, 0, 0, 0);
    vec[3]  = mk(0, 3'b101, 1, 2, 5, 0, 0, 1, 2, 5);
    vec[4]  = mk(0, 3'b010, 1, 2, 5, 1, 0, 1, 3, 6);
    vec[5]  = mk(0, 3'b001, 1, 2, 5, 0, 1, 2, 2, 4);
    vec[6]  = mk(0, 3'b100, 1, 2, 5, 0, 0, 1, 2, 5);
    vec[7]  = mk(0, 3'b011, 1, 2, 5, 0, 0, 1, 2, 5);
    vec[8]  = mk(0, 3'b010, 1, 7, 3, 1, 0, 1, 0, 4);
    vec[9]  = mk(0, 3'b001, 7, 2, 3, 0, 1, 0, 2, 2);
    vec[10] = mk(0, 3'b111, 4, 6, 2, 0, 0, 4, 6, 2);
    vec[11] = mk(0, 3'b110, 3, 5, 1, 0, 0, 3, 5, 1);
    vec[12] = mk(1, 3'b001, 5, 5, 3, 0, 0, 0, 0, 0);
    vec[13] = mk(0, 3'b010, 6, 0, 7, 1, 0, 6, 1, 8);
`ifdef FIFO_CAL_ADDR_GUARD_EN
    vec[14] = mk(0, 3'b001, 2, 2, 0, 0, 0, 2, 2, 0);
    vec[15] = mk(0, 3'b010, 2, 2, 8, 0, 0, 2, 2, 8);
`else
    vec[14] = mk(0, 3'b001, 2, 2, 0, 0, 1, 3, 2, 15);
    vec[15] = mk(0, 3'b010, 2, 2, 8, 1, 0, 2, 3, 9);
`endif
    vec[16] = mk(0, 3'b001, 0, 4, 8, 0, 1, 1, 4, 7);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].r, vec[i].st, vec[i].h, vec[i].t, vec[i].c);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), outs(),
            pack(vec[i].ewe, vec[i].ere, vec[i].eh, vec[i].et, vec[i].ec));
    end

    // Back-to-back WRITE then READ: one-cycle pulses, never overlapping.
    drive(0, 3'b101, 2, 2, 3);
    @(posedge clk);
    #1;
    check("b2b_idle", outs(), pack(0, 0, 2, 2, 3));
    drive(0, 3'b010, 2, 2, 3);
    #1;
    check("b2b_latency", outs(), pack(0, 0, 2, 2, 3));
    @(posedge clk);
    #1;
    check("b2b_write", outs(), pack(1, 0, 2, 3, 4));
    drive(0, 3'b001, 2, 3, 4);
    @(posedge clk);
    #1;
    check("b2b_read", outs(), pack(0, 1, 3, 3, 3));
    drive(0, 3'b101, 3, 3, 3);
    @(posedge clk);
    #1;
    check("b2b_after", outs(), pack(0, 0, 3, 3, 3));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_cal_addr.md
Name: fifo_cal_addr

Overview:
Address/count calculator for an 8-entry circular FIFO.
- Takes the current FIFO controller state plus the current head, tail and data count.
- Produces the write/read enables and the next head, tail and count for the FIFO storage and pointer registers.
- All outputs are registered, with one-cycle latency from inputs to outputs.
- Sits between the FIFO next-state logic and the register file / pointer flops.

Parameters:
- AW, 3, pointer width; FIFO depth = 2**AW = 8.
- CW, 4, data-count width (AW+1); holds 0..8.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- state  input  3  current FIFO controller state (encoding below).
- head  input  AW  current read pointer.
- tail  input  AW  current write pointer.
- data_count  input  CW  current number of stored entries.
- we  output  1  write enable to the storage array (registered).
- re  output  1  read enable to the storage array (registered).
- next_head  output  AW  next read pointer (registered).
- next_tail  output  AW  next write pointer (registered).
- next_data_count  output  CW  next entry count (registered).

Behaviour:
- State encoding: INIT=3'b000, READ=3'b001, WRITE=3'b010, RD_ERROR=3'b011, WR_ERROR=3'b100, NO_OP=3'b101. Codes 110 and 111 are illegal.
- Each rising clk edge with rst=1: we=0, re=0, next_head=0, next_tail=0, next_data_count=0. Reset mid-operation overrides any state in that cycle.
- Each rising clk edge with rst=0, outputs are loaded from a combinational decode of the inputs sampled at that edge (latency 1 cycle):
  - INIT: we=0, re=0, next_head=0, next_tail=0, next_data_count=0.
  - NO_OP: we=0, re=0, next_head=head, next_tail=tail, next_data_count=data_count.
  - WRITE: we=1, re=0, next_tail=tail+1 (mod 2**AW; 7 wraps to 0), next_head=head, next_data_count=data_count+1.
  - READ: we=0, re=1, next_head=head+1 (mod 2**AW; 7 wraps to 0), next_tail=tail, next_data_count=data_count-1.
  - WR_ERROR, RD_ERROR: we=0, re=0, all next_* = current inputs (hold).
  - Illegal codes 110/111: treated exactly as NO_OP.
- we and re are never both 1.
- Count arithmetic is CW bits wide and unguarded: the upstream FSM guarantees no WRITE when data_count=8 and no READ when data_count=0. Without the optional feature, violating this wraps modulo 2**CW.
- No internal state other than the output registers.

Optional Feature:
- Macro: FIFO_CAL_ADDR_GUARD_EN.
- When defined:
  - WRITE with data_count==2**AW is treated as WR_ERROR: we=0, all next_* hold.
  - READ with data_count==0 is treated as RD_ERROR: re=0, all next_* hold.
- When undefined: no guard; behaviour exactly as specified above.

Decomposition:
- Shared package fifo_pkg holds:
  - state encoding localparams (INIT, READ, WRITE, RD_ERROR, WR_ERROR, NO_OP);
  - AW/CW defaults and a 3-bit state typedef.
- This package is shared with the FIFO FSM and top.
- One natural sub-module: fifo_cal_addr_comb, the pure combinational decode. fifo_cal_addr instantiates it and adds the output register stage with synchronous reset.

Test Plan:
- Reset: rst=1 with state=WRITE, head=1, tail=2, count=5 for one edge -> all outputs 0. Deassert rst -> next edge gives we=1, next_tail=3, next_head=1, count=6.
- Sweep states with head=1, tail=2, count=5, one state per cycle, checking outputs one cycle later:
  - INIT -> we=0, re=0, 0/0/0.
  - NO_OP -> we=0, re=0, 1/2/5.
  - WRITE -> we=1, re=0, next_tail=3, count=6.
  - READ -> we=0, re=1, next_head=2, count=4.
  - WR_ERROR and RD_ERROR -> we=0, re=0, 1/2/5.
- Wrap: WRITE with tail=7, count=3 -> next_tail=0, count=4. READ with head=7, count=3 -> next_head=0, count=2.
- Illegal state 3'b111 with head=4, tail=6, count=2 -> we=0, re=0, outputs 4/6/2.
- Guard (FIFO_CAL_ADDR_GUARD_EN defined):
  - WRITE with count=8 -> we=0, outputs hold.
  - READ with count=0 -> re=0, outputs hold.
  - Macro undefined: READ with count=0 -> re=1, count=15.
- Back-to-back: WRITE then READ on consecutive cycles -> we and re each pulse for exactly one cycle, one cycle after the corresponding input, never simultaneously.
